usb_tx: RTL and testbench
=========================

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 Parameters: none; bit rate fixed at 12 Mb/s (4 clk_48m cycles per bit).
REQ-002 clk_48m  input  1  48 MHz clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pkt_start  input  1  one-cycle request to send a packet; sampled only when idle.
REQ-005 pkt_pid  input  4  packet PID (low nibble); held stable from pkt_start to pkt_done.
REQ-006 pkt_len  input  10  payload byte count (0..1023) for data PIDs; held stable like pkt_pid.
REQ-007 pkt_data  input  8  current payload byte; valid whenever the block may pulse pkt_data_ack.
REQ-008 pkt_data_ack  output  1  one-cycle pulse; pkt_data byte consumed, source advances to next byte.
REQ-009 pkt_done  output  1  one-cycle pulse after EOP completes.
REQ-010 phy_tx_dp, phy_tx_dn  output  1 each  line drive levels.
REQ-011 phy_tx_en  output  1  output-driver enable.

Function
REQ-012 Bit timer: free-running 2-bit counter while busy; bit strobe br_now once per 4 cycles.
REQ-013 Line states: J = dp 1/dn 0; K = dp 0/dn 1; SE0 = dp 0/dn 0; idle drives J with phy_tx_en 0.
REQ-014 NRZI: logical 0 toggles J/K, logical 1 holds; encoder starts from J at each packet.
REQ-015 Bit stuffing: after six consecutive logical 1s, one 0 inserted (bs_now) before next data bit; counter reset by any 0 incl. stuffed; stuffing applies to the final bit before EOP.
REQ-016 Bit order on wire: SYNC 00000001 (wire KJKJKJKK), PID byte {~pid, pid}, then payload, then CRC; every byte LSB first.
REQ-017 Data PIDs (pid[1:0]=11): send exactly pkt_len payload bytes, then CRC16.
REQ-018 Non-data PIDs: send SYNC and PID only.
REQ-019 CRC16: poly 0x8005, init 0xFFFF, over payload bits only, transmitted ones-complemented, LSB first; pkt_len 0 gives CRC bytes 0x00 0x00.
REQ-020 pkt_data_ack pulses exactly once per payload byte, in the cycle the byte loads into the shift register; pulses total pkt_len.
REQ-021 EOP after last bit (incl. any stuffed bit): SE0 2 bit times, J 1 bit time, then phy_tx_en 0.
REQ-022 phy_tx_en asserts no later than 2 cycles after pkt_start; first SYNC bit lasts 4 cycles.
REQ-023 pkt_done pulses in the cycle phy_tx_en falls; next pkt_start accepted from the following cycle.
REQ-024 pkt_start while busy ignored; no queuing.
REQ-025 Packet-layer FSM: IDLE -> SYNC -> PID -> (DATA -> CRC_LO -> CRC_HI)? -> DONE -> IDLE; DATA skipped if pkt_len 0.
REQ-026 Low-level FSM: IDLE -> DATA (bits via start/bit/last/ack handshake) -> EOP_SE0 -> EOP_J -> IDLE.
REQ-027 Internal handshake: ll_start one cycle; ll_bit/ll_last valid until ll_ack; ll_ack pulses on br_now when no stuff bit pending.

Reset
REQ-028 rst: both FSMs to IDLE, counters/CRC/shift registers cleared, phy_tx_en 0, dp 1, dn 0, pkt_data_ack 0, pkt_done 0.
REQ-029 rst mid-packet: phy_tx_en 0 next cycle, no pkt_done, no further pkt_data_ack.

Structure
REQ-030 Shared package: PID constants (OUT, IN, SOF, SETUP, DATA0/1/2, MDATA, ACK, NAK, STALL), CRC16 poly/init, line-state encodings.
REQ-031 Sub-module usb_tx_ll (timer, stuffing, NRZI, EOP) under usb_tx; packet sequencing, byte shifting and CRC in top level.

Verification
REQ-032 ACK (pid 0010) -> wire KJKJKJKK + NRZI of 0xD2 LSB first, 64 bit cycles, SE0 8 cycles, J 4 cycles, pkt_done once, zero pkt_data_ack.
REQ-033 DATA0 (0011), pkt_len 256, bytes 8c 1a f2 f0 then 00 -> PID 0xC3, exactly 256 acks, CRC matches CRC16 reference model.
REQ-034 DATA1 (1011), pkt_len 0 -> PID 0x4B then CRC bytes 00 00, no acks.
REQ-035 DATA0 payload FF FF -> stuffed 0 after each run of six 1s; every bit exactly 4 cycles; decoded stream equals input.
REQ-036 rst pulse mid-payload -> phy_tx_en 0 next cycle, no pkt_done; fresh ACK then sends correctly.
REQ-037 pkt_start pulsed during transmission -> ignored; exactly one pkt_done per accepted start.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmitter: PIDs, CRC16 constants,
// line-state encodings, FSM state types and the debug view of both FSMs.
package usb_tx_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // SYNC pattern 00000001 as a byte shifted out LSB first
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Encoded as {dp, dn}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10
    } line_t;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_SYNC,
        PK_PID,
        PK_DATA,
        PK_CRC_LO,
        PK_CRC_HI,
        PK_DONE
    } pk_state_t;

    typedef enum logic [1:0] {
        LL_IDLE,
        LL_DATA,
        LL_EOP_SE0,
        LL_EOP_J
    } ll_state_t;

    typedef struct packed {
        pk_state_t pk_state;
        ll_state_t ll_state;
    } tx_dbg_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // One serial CRC16 step on the bit-reversed register, so that the low byte of
    // the complemented register is already in wire order.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        logic [15:0] nxt;
        nxt = {1'b0, crc[15:1]};
        if (crc[0] ^ b) nxt = nxt ^ reflect16(CRC16_POLY);
        return nxt;
    endfunction

endpackage

// File: rtl/usb_tx_ll.sv
// Low-level USB transmitter: bit timer, bit stuffing, NRZI encoding and EOP.
// Bits arrive through a start/bit/last/ack handshake from the packet layer.
module usb_tx_ll
    import usb_tx_pkg::*;
(
    input  logic      clk_48m,
    input  logic      rst,
    input  logic      ll_start_i,
    input  logic      ll_bit_i,
    input  logic      ll_last_i,
    output logic      ll_ack_o,
    output logic      ll_done_o,
    output logic      phy_tx_dp_o,
    output logic      phy_tx_dn_o,
    output logic      phy_tx_en_o,
    output ll_state_t state_o
);

    // Handshake: ll_start is a one-cycle pulse; ll_bit/ll_last stay valid until
    // ll_ack, which pulses on a bit strobe whenever no stuff bit is being sent.

    ll_state_t  state_q, state_d;
    logic [1:0] cnt_q;
    logic [2:0] ones_q, ones_d;
    logic       lvl_q, lvl_d;     // 1 = J
    logic       last_q, last_d;   // final bit taken, trailing stuff bit still owed
    logic       eop_q, eop_d;
    line_t      line_q, line_d;
    logic       en_q, en_d;
    logic       done_q;

    logic br_now, bs_now, tx_bit, cur_lvl;

    assign br_now   = (state_q != LL_IDLE) && (cnt_q == 2'd3);
    assign bs_now   = (ones_q == 3'd6);
    assign tx_bit   = bs_now ? 1'b0 : ll_bit_i;
    assign cur_lvl  = tx_bit ? lvl_q : ~lvl_q;
    assign ll_ack_o = br_now && (state_q == LL_DATA) && !bs_now;

    always_ff @(posedge clk_48m) begin
        if (rst) begin
            state_q <= LL_IDLE;
            cnt_q   <= 2'd0;
            ones_q  <= 3'd0;
            lvl_q   <= 1'b1;
            last_q  <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == LL_IDLE) ? 2'd0 : cnt_q + 2'd1;
            ones_q  <= ones_d;
            lvl_q   <= lvl_d;
            last_q  <= last_d;
            eop_q   <= eop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        lvl_d   = lvl_q;
        last_d  = last_q;
        eop_d   = eop_q;
        case (state_q)
            LL_IDLE: begin
                if (ll_start_i) begin
                    state_d = LL_DATA;
                    ones_d  = 3'd0;
                    lvl_d   = 1'b1;
                    last_d  = 1'b0;
                    eop_d   = 1'b0;
                end
            end
            LL_DATA: begin
                if (br_now) begin
                    lvl_d  = cur_lvl;
                    ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
                    if (bs_now) begin
                        if (last_q) state_d = LL_EOP_SE0;
                    end else if (ll_last_i) begin
                        // A sixth one on the final bit still needs its stuff bit
                        if (tx_bit && (ones_q == 3'd5)) last_d = 1'b1;
                        else                            state_d = LL_EOP_SE0;
                    end
                end
            end
            LL_EOP_SE0: begin
                if (br_now) begin
                    if (eop_q) state_d = LL_EOP_J;
                    eop_d = 1'b1;
                end
            end
            LL_EOP_J: begin
                if (br_now) state_d = LL_IDLE;
            end
            default: state_d = LL_IDLE;
        endcase
    end

    always_comb begin
        line_d = LINE_J;
        en_d   = 1'b1;
        case (state_q)
            LL_IDLE:    en_d   = 1'b0;
            LL_DATA:    line_d = cur_lvl ? LINE_J : LINE_K;
            LL_EOP_SE0: line_d = LINE_SE0;
            default:    line_d = LINE_J;
        endcase
    end

    // Line outputs are registered; done lines up with the cycle enable drops
    always_ff @(posedge clk_48m) begin
        if (rst) begin
            line_q <= LINE_J;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            line_q <= line_d;
            en_q   <= en_d;
            done_q <= (state_q == LL_IDLE) && en_q;
        end
    end

    assign phy_tx_dp_o = line_q[1];
    assign phy_tx_dn_o = line_q[0];
    assign phy_tx_en_o = en_q;
    assign ll_done_o   = done_q;
    assign state_o     = state_q;

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: sequences SYNC, PID, payload and CRC16 as
// bytes shifted LSB first into usb_tx_ll, which handles line-level encoding.
module usb_tx
    import usb_tx_pkg::*;
(
    input  logic        clk_48m,
    input  logic        rst,
    input  logic        pkt_start_i,
    input  logic [3:0]  pkt_pid_i,
    input  logic [9:0]  pkt_len_i,
    input  logic [7:0]  pkt_data_i,
    output logic        pkt_data_ack_o,
    output logic        pkt_done_o,
    output logic        phy_tx_dp_o,
    output logic        phy_tx_dn_o,
    output logic        phy_tx_en_o,
    output tx_dbg_t     dbg_o
);

    pk_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [9:0]  bytes_q, bytes_d;
    logic [15:0] crc_q, crc_d;     // bit-reversed CRC16 register
    logic [15:0] crc_bit;

    logic      ll_start, ll_last, ll_ack, ll_done, load_data;
    logic      data_pid, byte_end;
    ll_state_t ll_state;

    assign data_pid = is_data_pid(pkt_pid_i);
    assign byte_end = ll_ack && (bitcnt_q == 3'd7);
    assign crc_bit  = crc16_bit(crc_q, shift_q[0]);

    always_ff @(posedge clk_48m) begin
        if (rst) begin
            state_q  <= PK_IDLE;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            bytes_q  <= 10'd0;
            crc_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            bytes_q  <= bytes_d;
            crc_q    <= crc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        bytes_d  = bytes_q;
        crc_d    = crc_q;
        if (ll_ack) begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
        end
        case (state_q)
            PK_IDLE: begin
                if (pkt_start_i) begin
                    state_d  = PK_SYNC;
                    shift_d  = SYNC_BYTE;
                    bitcnt_d = 3'd0;
                    bytes_d  = 10'd0;
                    crc_d    = CRC16_INIT;
                end
            end
            PK_SYNC: begin
                if (byte_end) begin
                    state_d = PK_PID;
                    shift_d = {~pkt_pid_i, pkt_pid_i};
                end
            end
            PK_PID: begin
                if (byte_end) begin
                    if (!data_pid) begin
                        state_d = PK_DONE;
                    end else if (pkt_len_i == 10'd0) begin
                        state_d = PK_CRC_LO;
                        shift_d = ~crc_q[7:0];
                    end else begin
                        state_d = PK_DATA;
                        shift_d = pkt_data_i;
                        bytes_d = 10'd1;
                    end
                end
            end
            PK_DATA: begin
                if (ll_ack) crc_d = crc_bit;
                if (byte_end) begin
                    // The CRC byte must include the payload bit acked this cycle
                    if (bytes_q == pkt_len_i) begin
                        state_d = PK_CRC_LO;
                        shift_d = ~crc_bit[7:0];
                    end else begin
                        shift_d = pkt_data_i;
                        bytes_d = bytes_q + 10'd1;
                    end
                end
            end
            PK_CRC_LO: begin
                if (byte_end) begin
                    state_d = PK_CRC_HI;
                    shift_d = ~crc_q[15:8];
                end
            end
            PK_CRC_HI: begin
                if (byte_end) state_d = PK_DONE;
            end
            PK_DONE: begin
                if (ll_done) state_d = PK_IDLE;
            end
            default: state_d = PK_IDLE;
        endcase
    end

    always_comb begin
        ll_start  = 1'b0;
        ll_last   = 1'b0;
        load_data = 1'b0;
        case (state_q)
            PK_IDLE:   ll_start  = pkt_start_i;
            PK_PID: begin
                ll_last   = !data_pid && (bitcnt_q == 3'd7);
                load_data = byte_end && data_pid && (pkt_len_i != 10'd0);
            end
            PK_DATA:   load_data = byte_end && (bytes_q != pkt_len_i);
            PK_CRC_HI: ll_last   = (bitcnt_q == 3'd7);
            default: ;
        endcase
    end

    usb_tx_ll u_ll (
        .clk_48m     (clk_48m),
        .rst         (rst),
        .ll_start_i  (ll_start),
        .ll_bit_i    (shift_q[0]),
        .ll_last_i   (ll_last),
        .ll_ack_o    (ll_ack),
        .ll_done_o   (ll_done),
        .phy_tx_dp_o (phy_tx_dp_o),
        .phy_tx_dn_o (phy_tx_dn_o),
        .phy_tx_en_o (phy_tx_en_o),
        .state_o     (ll_state)
    );

    assign pkt_data_ack_o = load_data && !rst;
    assign pkt_done_o     = ll_done;
    assign dbg_o          = '{pk_state: state_q, ll_state: ll_state};

endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: decodes the wire (NRZI, destuffing, bit timing, EOP) and
// compares recovered bytes against an expected-byte queue built from a CRC16 model.
module tb_usb_tx;
  import usb_tx_pkg::*;

  logic       clk_48m = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_start = 1'b0;
  logic [3:0] pkt_pid = 4'd0;
  logic [9:0] pkt_len = 10'd0;
  logic [7:0] pkt_data;
  logic       pkt_data_ack, pkt_done, dp, dn, en;
  tx_dbg_t    dbg;

  always #10 clk_48m = ~clk_48m;

  usb_tx dut (
    .clk_48m        (clk_48m),
    .rst            (rst),
    .pkt_start_i    (pkt_start),
    .pkt_pid_i      (pkt_pid),
    .pkt_len_i      (pkt_len),
    .pkt_data_i     (pkt_data),
    .pkt_data_ack_o (pkt_data_ack),
    .pkt_done_o     (pkt_done),
    .phy_tx_dp_o    (dp),
    .phy_tx_dn_o    (dn),
    .phy_tx_en_o    (en),
    .dbg_o          (dbg)
  );

  // payload source: advances one byte per ack
  logic [7:0] pay_mem [0:1023];
  logic [9:0] src_idx;
  logic       src_clr = 1'b1;
  int         ack_cnt;
  int         done_cnt;

  assign pkt_data = pay_mem[src_idx];

  always @(posedge clk_48m) begin
    if (src_clr) begin
      src_idx  <= 10'd0;
      ack_cnt  <= 0;
      done_cnt <= 0;
    end else begin
      if (pkt_data_ack) begin
        src_idx <= src_idx + 10'd1;
        ack_cnt <= ack_cnt + 1;
      end
      if (pkt_done) done_cnt <= done_cnt + 1;
    end
  end

  logic [7:0] exp_q[$];
  int checks;
  int errors;
  int smp_n;
  int poke_n;

  typedef struct {
    logic [3:0] pid;
    logic [9:0] len;
    int         pattern;
    int         poke;
    int         exp_acks;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_48m);
    smp_n++;
    pkt_start = (smp_n == poke_n);
  endtask

  task automatic fill(input int pattern, input logic [9:0] len);
    for (int i = 0; i < int'(len); i++) begin
      case (pattern)
        0: case (i)
             0: pay_mem[i] = 8'h8c;
             1: pay_mem[i] = 8'h1a;
             2: pay_mem[i] = 8'hf2;
             3: pay_mem[i] = 8'hf0;
             default: pay_mem[i] = 8'h00;
           endcase
        1: pay_mem[i] = 8'hff;
        default: pay_mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Expected wire bytes: SYNC, PID, payload, then ~CRC16 with register bit 15 first
  task automatic push_expected(input logic [3:0] pid, input logic [9:0] len);
    logic [15:0] crc, t;
    logic [7:0]  bt, lo, hi;
    logic        fb;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back({~pid, pid});
    if (pid[1:0] == 2'b11) begin
      crc = 16'hFFFF;
      for (int i = 0; i < int'(len); i++) begin
        bt = pay_mem[i];
        exp_q.push_back(bt);
        for (int j = 0; j < 8; j++) begin
          fb  = crc[15] ^ bt[j];
          crc = {crc[14:0], 1'b0};
          if (fb) crc = crc ^ 16'h8005;
        end
      end
      t = ~crc;
      for (int j = 0; j < 8; j++) begin
        lo[j] = t[15-j];
        hi[j] = t[7-j];
      end
      exp_q.push_back(lo);
      exp_q.push_back(hi);
    end
  endtask

  task automatic run_packet(input logic [3:0] pid, input logic [9:0] len, input int poke,
                            output int bit_cycles);
    logic [1:0] l0;
    logic       ok, prev_j, got_se0, bitv;
    logic [7:0] cur, want;
    int         ones, nb;
    pkt_pid = pid;
    pkt_len = len;
    smp_n   = -1000;
    poke_n  = poke;
    @(negedge clk_48m);
    pkt_start = 1'b1;
    @(negedge clk_48m);
    pkt_start = 1'b0;
    @(negedge clk_48m);
    smp_n = 0;
    chk("en_rise", en, 1);
    ok = 1'b1; prev_j = 1'b1; got_se0 = 1'b0; ones = 0; nb = 0; cur = 8'd0;
    bit_cycles = 0;
    for (int b = 0; b < 12000 && !got_se0; b++) begin
      l0 = {dp, dn};
      if (en !== 1'b1) ok = 1'b0;
      for (int k = 1; k < 4; k++) begin
        step();
        if ({dp, dn} !== l0 || en !== 1'b1) ok = 1'b0;
      end
      if (l0 == 2'b00) begin
        got_se0 = 1'b1;
      end else begin
        if (l0 == 2'b11) ok = 1'b0;
        bitv   = ((l0 == 2'b10) == prev_j);
        prev_j = (l0 == 2'b10);
        bit_cycles += 4;
        if (ones == 6) begin
          chk("stuff_bit", bitv, 0);
          ones = 0;
        end else begin
          cur  = {bitv, cur[7:1]};
          nb++;
          ones = bitv ? ones + 1 : 0;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) chk("extra_byte", cur, 32'hFFFF_FFFF);
            else begin
              want = exp_q.pop_front();
              chk("byte", cur, want);
            end
          end
        end
        step();
      end
    end
    chk("se0_seen", got_se0, 1);
    chk("bit_timing", ok, 1);
    chk("byte_align", nb, 0);
    chk("bytes_left", exp_q.size(), 0);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if ({en, dp, dn} !== 3'b100) ok = 1'b0;
    end
    chk("eop_se0_8", ok, 1);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if ({en, dp, dn} !== 3'b110 || pkt_done !== 1'b0) ok = 1'b0;
    end
    chk("eop_j_4", ok, 1);
    step();
    chk("done_at_en_fall", {en, pkt_done, dp, dn}, 4'b0110);
    poke_n = -1;
    pkt_start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, a0;
    checks = 0; errors = 0; smp_n = 0; poke_n = -1;

    vecs[0] = '{PID_ACK,   10'd5,   0, -1,   0,  64};
    vecs[1] = '{PID_DATA0, 10'd256, 0, -1, 256,  -1};
    vecs[2] = '{PID_DATA1, 10'd0,   0, -1,   0, 128};
    vecs[3] = '{PID_DATA0, 10'd2,   1, -1,   2,  -1};
    vecs[4] = '{PID_NAK,   10'd0,   0, -1,   0,  64};
    vecs[5] = '{PID_DATA1, 10'd5,   2, 50,   5,  -1};
    vecs[6] = '{PID_DATA2, 10'd1,   2, -1,   1,  -1};
    vecs[7] = '{PID_SETUP, 10'd3,   0, 20,   0,  64};

    repeat (4) @(negedge clk_48m);
    chk("reset_line", {en, dp, dn}, 3'b010);
    chk("reset_ack", pkt_data_ack, 0);
    chk("reset_done", pkt_done, 0);
    chk("reset_dbg", dbg, {PK_IDLE, LL_IDLE});
    rst = 1'b0;
    src_clr = 1'b0;
    repeat (3) @(negedge clk_48m);

    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].pattern, vecs[v].len);
      src_clr = 1'b1;
      @(negedge clk_48m);
      src_clr = 1'b0;
      push_expected(vecs[v].pid, vecs[v].len);
      run_packet(vecs[v].pid, vecs[v].len, vecs[v].poke, cyc);
      repeat (10) @(negedge clk_48m);
      chk("acks", ack_cnt, vecs[v].exp_acks);
      chk("done_count", done_cnt, 1);
      chk("idle_line", {en, dp, dn}, 3'b010);
      if (vecs[v].exp_cycles >= 0) chk("bit_cycles", cyc, vecs[v].exp_cycles);
    end

    // reset in the middle of a payload
    fill(2, 10'd20);
    src_clr = 1'b1;
    @(negedge clk_48m);
    src_clr = 1'b0;
    pkt_pid = PID_DATA0;
    pkt_len = 10'd20;
    pkt_start = 1'b1;
    @(negedge clk_48m);
    pkt_start = 1'b0;
    for (int i = 0; i < 3000 && ack_cnt < 3; i++) @(negedge clk_48m);
    chk("acks_before_rst", ack_cnt >= 3, 1);
    rst = 1'b1;
    @(negedge clk_48m);
    rst = 1'b0;
    chk("rst_en_off", {en, dp, dn}, 3'b010);
    a0 = ack_cnt;
    repeat (60) @(negedge clk_48m);
    chk("rst_no_ack", ack_cnt, a0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_dbg", dbg, {PK_IDLE, LL_IDLE});

    // fresh ACK after the reset
    src_clr = 1'b1;
    @(negedge clk_48m);
    src_clr = 1'b0;
    push_expected(PID_ACK, 10'd0);
    run_packet(PID_ACK, 10'd0, -1, cyc);
    repeat (10) @(negedge clk_48m);
    chk("post_rst_cycles", cyc, 64);
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_acks", ack_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
